// File: rtl/xfer_pkg.sv
// Shared types and defaults for the transfer address counter.
package xfer_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam int XFER_AW_DEF = 3;
endpackage

// File: rtl/xfer_addr_counter_if.sv
// Request/status bundle for xfer_addr_counter; dir exists only with XFER_ADDR_DOWN_EN.
interface xfer_addr_counter_if
  import xfer_pkg::*;
#(
  parameter int AW = XFER_AW_DEF,
  parameter int LW = AW + 1
) ();
  logic          start;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic          inc;
  logic          abort;
`ifdef XFER_ADDR_DOWN_EN
  logic          dir;
`endif
  logic [AW-1:0] addr;
  logic [LW-1:0] remaining;
  logic          busy;
  logic          last;
  logic          done;
  logic          err;

`ifdef XFER_ADDR_DOWN_EN
  modport master (output start, base, len, inc, abort, dir,
                  input  addr, remaining, busy, last, done, err);
  modport slave  (input  start, base, len, inc, abort, dir,
                  output addr, remaining, busy, last, done, err);
`else
  modport master (output start, base, len, inc, abort,
                  input  addr, remaining, busy, last, done, err);
  modport slave  (input  start, base, len, inc, abort,
                  output addr, remaining, busy, last, done, err);
`endif
endinterface

// File: rtl/xfer_addr_counter.sv
// Beat address counter for a burst transfer: IDLE/RUN FSM with done/err pulses.
// Optional XFER_ADDR_DOWN_EN adds a per-transfer count direction (bus.dir).
module xfer_addr_counter
  import xfer_pkg::*;
#(
  parameter int AW = XFER_AW_DEF,
  parameter int LW = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  xfer_addr_counter_if.slave bus
);
  state_t        state;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] rem_q;
  logic          done_q, err_q;
  logic [AW-1:0] addr_nxt;

`ifdef XFER_ADDR_DOWN_EN
  logic dir_q;
  assign addr_nxt = dir_q ? addr_q - AW'(1) : addr_q + AW'(1);
`else
  assign addr_nxt = addr_q + AW'(1);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef XFER_ADDR_DOWN_EN
      dir_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          // abort alongside start silently cancels the request
          if (bus.start && !bus.abort) begin
            if (bus.len != '0) begin
              state  <= RUN;
              addr_q <= bus.base;
              rem_q  <= bus.len;
`ifdef XFER_ADDR_DOWN_EN
              dir_q  <= bus.dir;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state <= IDLE;
            rem_q <= '0;
          end else if (bus.inc) begin
            if (rem_q == LW'(1)) begin
              // final beat: addr keeps the last beat's address
              state  <= IDLE;
              rem_q  <= '0;
              done_q <= 1'b1;
            end else begin
              addr_q <= addr_nxt;
              rem_q  <= rem_q - LW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.addr      = addr_q;
  assign bus.remaining = rem_q;
  assign bus.busy      = (state == RUN);
  assign bus.last      = (state == RUN) && (rem_q == LW'(1));
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_xfer_addr_counter.sv
// Directed vector bench for xfer_addr_counter at AW=3, LW=4.
module tb_xfer_addr_counter;
  localparam int AW = 3;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  xfer_addr_counter_if #(.AW(AW), .LW(LW)) bus ();
  xfer_addr_counter #(.AW(AW), .LW(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic          start;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic          inc;
    logic          abort;
    logic          dir;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_rem;
    logic          e_busy;
    logic          e_last;
    logic          e_done;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic st, input int b, input int l, input logic in, input logic ab,
                     input logic d, input int ea, input int er, input logic eb, input logic el,
                     input logic ed, input logic ee);
    vec_t v;
    v.start = st; v.base = AW'(b); v.len = LW'(l); v.inc = in; v.abort = ab; v.dir = d;
    v.e_addr = AW'(ea); v.e_rem = LW'(er); v.e_busy = eb; v.e_last = el;
    v.e_done = ed; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input int b, input int l, input logic in,
                       input logic ab, input logic d);
    bus.start = st; bus.base = AW'(b); bus.len = LW'(l); bus.inc = in; bus.abort = ab;
`ifdef XFER_ADDR_DOWN_EN
    bus.dir = d;
`else
    if (d) $display("note: dir requested but feature not built");
`endif
  endtask

  task automatic check(input string name, input logic [AW-1:0] ea, input logic [LW-1:0] er,
                       input logic eb, input logic el, input logic ed, input logic ee);
    logic [11:0] act, exp;
    act = {1'b0, bus.addr, bus.remaining, bus.busy, bus.last, bus.done, bus.err};
    exp = {1'b0, ea, er, eb, el, ed, ee};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got addr=%0d rem=%0d busy=%b last=%b done=%b err=%b, want addr=%0d rem=%0d busy=%b last=%b done=%b err=%b",
                  name, bus.addr, bus.remaining, bus.busy, bus.last, bus.done, bus.err,
                  ea, er, eb, el, ed, ee);
  endtask

  initial begin
    //   st b  l  inc ab dir  addr rem busy last done err
    add(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    add(1, 2, 3, 0, 0, 0,    2, 3, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    3, 2, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    4, 1, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,    4, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,    4, 0, 0, 0, 0, 0);
    add(1, 6, 4, 0, 0, 0,    6, 4, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    7, 3, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    0, 2, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    1, 1, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,    1, 0, 0, 0, 1, 0);
    add(1, 5, 0, 0, 0, 0,    1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0);
    add(1, 3, 2, 0, 1, 0,    1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    1, 0, 0, 0, 0, 0);
    add(1, 1, 5, 0, 0, 0,    1, 5, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    2, 4, 1, 0, 0, 0);
    add(1, 7, 2, 0, 0, 0,    2, 4, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    3, 3, 1, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0,    3, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,    3, 0, 0, 0, 0, 0);
    add(1, 7, 9, 0, 0, 0,    7, 9, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    0, 8, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0);
    add(1, 7, 1, 0, 0, 0,    7, 1, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,    7, 0, 0, 0, 1, 0);
`ifdef XFER_ADDR_DOWN_EN
    add(1, 1, 3, 0, 0, 1,    1, 3, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    0, 2, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    7, 1, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,    7, 0, 0, 0, 1, 0);
`endif

    drive(0, 0, 0, 0, 0, 0);
    #3;
    check("reset_async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].start, int'(vecs[i].base), int'(vecs[i].len), vecs[i].inc,
            vecs[i].abort, vecs[i].dir);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_rem, vecs[i].e_busy,
            vecs[i].e_last, vecs[i].e_done, vecs[i].e_err);
      @(negedge clk);
    end

    // reset mid-transfer must clear state without any clock edge
    drive(1, 5, 3, 0, 0, 0);
    @(posedge clk); #1;
    check("mid_run_start", 5, 3, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("mid_run_reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("reset_held", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 3, 2, 0, 0, 0);
    @(posedge clk); #1;
    check("post_reset_start", 3, 2, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    check("post_reset_last", 4, 1, 1, 1, 0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    check("post_reset_done", 4, 0, 0, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
